mem_req_stage: RTL and testbench

Memory-access request stage of the in-order MIPS pipeline, between the execute stage and `writeback_stage`. It latches one instruction from execute and, for loads and stores, drives a request on the SRAM-like data bus (`data_req`/`data_addr_ok`). Store data is aligned and byte strobes are generated for SB/SH/SW/SWL/SWR. At most one data transaction is outstanding, so every `data_data_ok` seen by writeback belongs to the instruction currently in WB.

---
 rtl/mem_req_stage_pkg.sv | 42 ++++
 rtl/mem_req_stage_align.sv | 65 ++++++
 rtl/mem_req_stage.sv | 162 ++++++++++++++++
 tb/tb_mem_req_stage.sv | 383 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_req_stage_pkg.sv
// Shared control-flag indices, bus size encodings and stage state type
// for the memory-access request stage.
package mem_req_stage_pkg;

    localparam int I_LB    = 0;
    localparam int I_LBU   = 1;
    localparam int I_LH    = 2;
    localparam int I_LHU   = 3;
    localparam int I_LW    = 4;
    localparam int I_LWL   = 5;
    localparam int I_LWR   = 6;
    localparam int I_SB    = 7;
    localparam int I_SH    = 8;
    localparam int I_SW    = 9;
    localparam int I_SWL   = 10;
    localparam int I_SWR   = 11;
    localparam int I_MEM_R = 12;
    localparam int I_MEM_W = 13;
    localparam int I_WEX   = 14;
    localparam int I_WWB   = 15;
    localparam int I_MAX   = 16;

    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_HOLD = 2'd2
    } stage_state_e;

    // Returns {adel, ades}; LWL/LWR/SWL/SWR are never misaligned.
    function automatic logic [1:0] addr_err(input logic [I_MAX-1:0] ctrl, input logic [1:0] off);
        logic adel;
        logic ades;
        adel = (ctrl[I_LW] && (off != 2'b00)) || ((ctrl[I_LH] || ctrl[I_LHU]) && off[0]);
        ades = (ctrl[I_SW] && (off != 2'b00)) || (ctrl[I_SH] && off[0]);
        return {adel, ades};
    endfunction

endpackage

// File: rtl/mem_req_stage_align.sv
// Combinational store-data alignment: maps (ctrl, eaddr, rt) to the bus
// write data, byte strobes, transfer size and word/byte address.
module store_align
    import mem_req_stage_pkg::*;
(
    input  logic [I_MAX-1:0] ctrl,
    input  logic [31:0]      eaddr,
    input  logic [31:0]      rt,
    output logic [31:0]      wdata,
    output logic [3:0]       wstrb,
    output logic [1:0]       size,
    output logic [31:0]      addr
);

    logic [1:0] off_s;
    logic [1:0] rev_s;
    logic [4:0] shl_s;
    logic [4:0] shr_s;
    logic       partial_s;

    assign off_s     = eaddr[1:0];
    assign rev_s     = 2'd3 - off_s;
    assign shl_s     = {off_s, 3'b000};
    assign shr_s     = {rev_s, 3'b000};
    assign partial_s = ctrl[I_LWL] | ctrl[I_LWR] | ctrl[I_SWL] | ctrl[I_SWR];
    assign addr      = partial_s ? {eaddr[31:2], 2'b00} : eaddr;

    // Store data replication/shift and byte-lane strobes
    always_comb begin
        wdata = 32'h0000_0000;
        wstrb = 4'b0000;
        if (ctrl[I_SB]) begin
            wdata = {4{rt[7:0]}};
            wstrb = 4'b0001 << off_s;
        end else if (ctrl[I_SH]) begin
            wdata = {2{rt[15:0]}};
            wstrb = 4'b0011 << off_s;
        end else if (ctrl[I_SW]) begin
            wdata = rt;
            wstrb = 4'b1111;
        end else if (ctrl[I_SWL]) begin
            wdata = rt >> shr_s;
            wstrb = 4'b1111 >> rev_s;
        end else if (ctrl[I_SWR]) begin
            wdata = rt << shl_s;
            wstrb = 4'b1111 << off_s;
        end else begin
            wdata = 32'h0000_0000;
            wstrb = 4'b0000;
        end
    end

    // Transfer size: partial-word ops always move a whole word
    always_comb begin
        size = SZ_W;
        if (ctrl[I_LB] || ctrl[I_LBU] || ctrl[I_SB]) begin
            size = SZ_B;
        end else if (ctrl[I_LH] || ctrl[I_LHU] || ctrl[I_SH]) begin
            size = SZ_H;
        end else begin
            size = SZ_W;
        end
    end

endmodule

// File: rtl/mem_req_stage.sv
// Memory-access request stage: latches one instruction from execute, issues
// its data-bus request and holds it until writeback takes it.
module mem_req_stage
    import mem_req_stage_pkg::*;
(
    input  logic             clk,
    input  logic             resetn,
    input  logic             valid_i,
    output logic             ready_o,
    input  logic [31:0]      pc_i,
    input  logic [31:0]      inst_i,
    input  logic [I_MAX-1:0] ctrl_i,
    input  logic [31:0]      result_i,
    input  logic [31:0]      rdata2_i,
    input  logic [4:0]       waddr_i,
    output logic             valid_o,
    input  logic             ready_i,
    output logic [31:0]      pc_o,
    output logic [31:0]      inst_o,
    output logic [I_MAX-1:0] ctrl_o,
    output logic [31:0]      result_o,
    output logic [31:0]      eaddr_o,
    output logic [31:0]      rdata2_o,
    output logic [4:0]       waddr_o,
    output logic             adel_o,
    output logic             ades_o,
    output logic             data_req,
    output logic             data_wr,
    output logic [1:0]       data_size,
    output logic [31:0]      data_addr,
    output logic [31:0]      data_wdata,
    output logic [3:0]       data_wstrb,
    input  logic             data_addr_ok,
    input  logic             data_data_ok
);

    stage_state_e state_r;
    logic         outst_r;
    logic         accept_s;
    logic [1:0]   err_s;
    logic         mem_go_s;
    logic [31:0]  wdata_s;
    logic [3:0]   wstrb_s;
    logic [1:0]   size_s;
    logic [31:0]  addr_s;

    store_align u_align (
        .ctrl  (ctrl_i),
        .eaddr (result_i),
        .rt    (rdata2_i),
        .wdata (wdata_s),
        .wstrb (wstrb_s),
        .size  (size_s),
        .addr  (addr_s)
    );

    assign err_s    = addr_err(ctrl_i, result_i[1:0]);
    assign mem_go_s = (ctrl_i[I_MEM_R] || ctrl_i[I_MEM_W]) && (err_s == 2'b00);
    assign ready_o  = (state_r == ST_IDLE) || ((state_r == ST_HOLD) && ready_i);
    assign accept_s = valid_i && ready_o;
    assign valid_o  = (state_r == ST_HOLD);
    // A new request may overlap the previous response's completion cycle.
    assign data_req = (state_r == ST_REQ) && (!outst_r || data_data_ok);

    // Stage FSM
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_r <= ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (accept_s) begin
                        state_r <= mem_go_s ? ST_REQ : ST_HOLD;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_REQ: begin
                    if (data_req && data_addr_ok) begin
                        state_r <= ST_HOLD;
                    end else begin
                        state_r <= ST_REQ;
                    end
                end
                ST_HOLD: begin
                    if (accept_s) begin
                        state_r <= mem_go_s ? ST_REQ : ST_HOLD;
                    end else if (ready_i) begin
                        state_r <= ST_IDLE;
                    end else begin
                        state_r <= ST_HOLD;
                    end
                end
                default: state_r <= ST_IDLE;
            endcase
        end
    end

    // Single outstanding-transaction flag; a same-cycle grant wins over completion
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            outst_r <= 1'b0;
        end else if (data_req && data_addr_ok) begin
            outst_r <= 1'b1;
        end else if (data_data_ok) begin
            outst_r <= 1'b0;
        end else begin
            outst_r <= outst_r;
        end
    end

    // Pipeline and bus-request fields, captured only on accept so they stay stable
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            pc_o       <= 32'h0000_0000;
            inst_o     <= 32'h0000_0000;
            ctrl_o     <= {I_MAX{1'b0}};
            result_o   <= 32'h0000_0000;
            eaddr_o    <= 32'h0000_0000;
            rdata2_o   <= 32'h0000_0000;
            waddr_o    <= 5'd0;
            adel_o     <= 1'b0;
            ades_o     <= 1'b0;
            data_wr    <= 1'b0;
            data_size  <= 2'd0;
            data_addr  <= 32'h0000_0000;
            data_wdata <= 32'h0000_0000;
            data_wstrb <= 4'b0000;
        end else if (accept_s) begin
            pc_o       <= pc_i;
            inst_o     <= inst_i;
            ctrl_o     <= ctrl_i;
            result_o   <= result_i;
            eaddr_o    <= result_i;
            rdata2_o   <= rdata2_i;
            waddr_o    <= waddr_i;
            adel_o     <= err_s[1];
            ades_o     <= err_s[0];
            data_wr    <= ctrl_i[I_MEM_W];
            data_size  <= size_s;
            data_addr  <= addr_s;
            data_wdata <= wdata_s;
            data_wstrb <= wstrb_s;
        end else begin
            pc_o       <= pc_o;
            inst_o     <= inst_o;
            ctrl_o     <= ctrl_o;
            result_o   <= result_o;
            eaddr_o    <= eaddr_o;
            rdata2_o   <= rdata2_o;
            waddr_o    <= waddr_o;
            adel_o     <= adel_o;
            ades_o     <= ades_o;
            data_wr    <= data_wr;
            data_size  <= data_size;
            data_addr  <= data_addr;
            data_wdata <= data_wdata;
            data_wstrb <= data_wstrb;
        end
    end

endmodule

// File: tb/tb_mem_req_stage.sv
// Bench for mem_req_stage: directed vector table, hand-written multi-cycle
// sequences and a randomized run against a transaction-level model.
module tb_mem_req_stage;
    import mem_req_stage_pkg::*;

    logic             clk = 1'b0;
    logic             resetn;
    logic             valid_i, ready_o, valid_o, ready_i;
    logic [31:0]      pc_i, inst_i, result_i, rdata2_i;
    logic [I_MAX-1:0] ctrl_i, ctrl_o;
    logic [4:0]       waddr_i, waddr_o;
    logic [31:0]      pc_o, inst_o, result_o, eaddr_o, rdata2_o;
    logic             adel_o, ades_o;
    logic             data_req, data_wr, data_addr_ok, data_data_ok;
    logic [1:0]       data_size;
    logic [31:0]      data_addr, data_wdata;
    logic [3:0]       data_wstrb;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    mem_req_stage dut (
        .clk(clk), .resetn(resetn), .valid_i(valid_i), .ready_o(ready_o),
        .pc_i(pc_i), .inst_i(inst_i), .ctrl_i(ctrl_i), .result_i(result_i),
        .rdata2_i(rdata2_i), .waddr_i(waddr_i), .valid_o(valid_o), .ready_i(ready_i),
        .pc_o(pc_o), .inst_o(inst_o), .ctrl_o(ctrl_o), .result_o(result_o),
        .eaddr_o(eaddr_o), .rdata2_o(rdata2_o), .waddr_o(waddr_o),
        .adel_o(adel_o), .ades_o(ades_o), .data_req(data_req), .data_wr(data_wr),
        .data_size(data_size), .data_addr(data_addr), .data_wdata(data_wdata),
        .data_wstrb(data_wstrb), .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok)
    );

    typedef enum int {OP_ADD, OP_LB, OP_LBU, OP_LH, OP_LHU, OP_LW, OP_LWL, OP_LWR,
                      OP_SB, OP_SH, OP_SW, OP_SWL, OP_SWR} op_e;

    typedef struct {
        logic [31:0] addr;
        logic [1:0]  size;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic        adel;
        logic        ades;
    } bus_exp_t;

    typedef struct {
        op_e         op;
        logic [31:0] addr;
        logic [31:0] rt;
        int          wait_cyc;
        bit          exp_req;
        logic [31:0] exp_addr;
        logic [31:0] exp_wdata;
        logic [3:0]  exp_wstrb;
        logic [1:0]  exp_size;
        bit          exp_adel;
        bit          exp_ades;
    } vec_t;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h want 0x%08h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic bit is_load(op_e op);
        return (op >= OP_LB) && (op <= OP_LWR);
    endfunction

    function automatic bit is_store(op_e op);
        return op >= OP_SB;
    endfunction

    function automatic logic [I_MAX-1:0] op_ctrl(op_e op);
        logic [I_MAX-1:0] c;
        c = '0;
        case (op)
            OP_LB:   c[I_LB]  = 1'b1;
            OP_LBU:  c[I_LBU] = 1'b1;
            OP_LH:   c[I_LH]  = 1'b1;
            OP_LHU:  c[I_LHU] = 1'b1;
            OP_LW:   c[I_LW]  = 1'b1;
            OP_LWL:  c[I_LWL] = 1'b1;
            OP_LWR:  c[I_LWR] = 1'b1;
            OP_SB:   c[I_SB]  = 1'b1;
            OP_SH:   c[I_SH]  = 1'b1;
            OP_SW:   c[I_SW]  = 1'b1;
            OP_SWL:  c[I_SWL] = 1'b1;
            OP_SWR:  c[I_SWR] = 1'b1;
            default: c[I_WEX] = 1'b1;
        endcase
        if (is_load(op)) begin
            c[I_MEM_R] = 1'b1;
            c[I_WWB]   = 1'b1;
        end
        if (is_store(op)) c[I_MEM_W] = 1'b1;
        if (op == OP_ADD) c[I_WWB] = 1'b1;
        return c;
    endfunction

    // Reference: bus request and error flags from the ISA's byte-lane rules
    function automatic bus_exp_t model(op_e op, logic [31:0] a, logic [31:0] rt);
        bus_exp_t e;
        int off;
        off     = int'(a[1:0]);
        e.addr  = a;
        e.size  = 2'd2;
        e.wdata = 32'h0;
        e.wstrb = 4'h0;
        e.adel  = 1'b0;
        e.ades  = 1'b0;
        case (op)
            OP_LB, OP_LBU: e.size = 2'd0;
            OP_LH, OP_LHU: begin e.size = 2'd1; e.adel = (off % 2) != 0; end
            OP_LW:         e.adel = off != 0;
            OP_LWL, OP_LWR: e.addr = a & 32'hFFFF_FFFC;
            OP_SB: begin
                e.size  = 2'd0;
                e.wdata = (rt & 32'hFF) * 32'h0101_0101;
                e.wstrb = 4'(1 << off);
            end
            OP_SH: begin
                e.size  = 2'd1;
                e.wdata = (rt & 32'hFFFF) * 32'h0001_0001;
                e.wstrb = 4'(3 << off);
                e.ades  = (off % 2) != 0;
            end
            OP_SW: begin e.wdata = rt; e.wstrb = 4'hF; e.ades = off != 0; end
            OP_SWL: begin
                e.addr  = a & 32'hFFFF_FFFC;
                e.wdata = rt >> (8 * (3 - off));
                e.wstrb = 4'(15 >> (3 - off));
            end
            OP_SWR: begin
                e.addr  = a & 32'hFFFF_FFFC;
                e.wdata = rt << (8 * off);
                e.wstrb = 4'(15 << off);
            end
            default: e.size = 2'd2;
        endcase
        return e;
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive_instr(op_e op, logic [31:0] a, logic [31:0] rt, logic [31:0] pc);
        valid_i  = 1'b1;
        ctrl_i   = op_ctrl(op);
        result_i = a;
        rdata2_i = rt;
        pc_i     = pc;
        inst_i   = ~pc;
        waddr_i  = pc[6:2];
    endtask

    task automatic run_vec(vec_t v, logic [31:0] pc);
        tick;
        drive_instr(v.op, v.addr, v.rt, pc);
        ready_i = 1'b0; data_addr_ok = 1'b0; data_data_ok = 1'b0;
        #2;
        chk("accept_ready", ready_o, 1);
        chk("accept_noreq", data_req, 0);
        tick;
        valid_i = 1'b0;
        if (v.exp_req) begin
            for (int w = 0; w <= v.wait_cyc; w++) begin
                data_addr_ok = (w == v.wait_cyc);
                #2;
                chk("req_high", data_req, 1);
                chk("req_addr", data_addr, v.exp_addr);
                chk("req_size", data_size, v.exp_size);
                chk("req_wstrb", data_wstrb, v.exp_wstrb);
                chk("req_wr", data_wr, is_store(v.op));
                if (is_store(v.op)) chk("req_wdata", data_wdata, v.exp_wdata);
                chk("req_novalid", valid_o, 0);
                tick;
            end
            data_addr_ok = 1'b0;
            data_data_ok = 1'b1;
        end
        ready_i = 1'b1;
        #2;
        chk("hold_valid", valid_o, 1);
        chk("hold_noreq", data_req, 0);
        chk("hold_adel", adel_o, v.exp_adel);
        chk("hold_ades", ades_o, v.exp_ades);
        chk("hold_result", result_o, v.addr);
        chk("hold_eaddr", eaddr_o, v.addr);
        chk("hold_rdata2", rdata2_o, v.rt);
        chk("hold_pc", pc_o, pc);
        chk("hold_ctrl", ctrl_o, op_ctrl(v.op));
        tick;
        data_data_ok = 1'b0;
        ready_i = 1'b0;
        #2;
        chk("drain_valid", valid_o, 0);
        chk("drain_noreq", data_req, 0);
        chk("drain_ready", ready_o, 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[14];
        bit have, cur_mem, cur_done, dok, exp_req, exp_valid, exp_rdy;
        int outst, ok_cd;
        op_e cur_op, n_op;
        logic [31:0] cur_a, cur_rt, cur_pc, n_a, n_rt, n_pc;
        bus_exp_t ce;

        tbl[0]  = '{OP_ADD, 32'hDEAD_BEEF, 32'h0000_0000, 0, 1'b0, 32'h0, 32'h0, 4'h0, 2'd0, 1'b0, 1'b0};
        tbl[1]  = '{OP_SB,  32'h0000_1003, 32'h1234_5678, 2, 1'b1, 32'h0000_1003, 32'h7878_7878, 4'b1000, 2'd0, 1'b0, 1'b0};
        tbl[2]  = '{OP_SWL, 32'h0000_2001, 32'hAABB_CCDD, 0, 1'b1, 32'h0000_2000, 32'h0000_AABB, 4'b0011, 2'd2, 1'b0, 1'b0};
        tbl[3]  = '{OP_SWR, 32'h0000_2001, 32'hAABB_CCDD, 0, 1'b1, 32'h0000_2000, 32'hBBCC_DD00, 4'b1110, 2'd2, 1'b0, 1'b0};
        tbl[4]  = '{OP_LW,  32'h0000_3002, 32'h0000_0000, 0, 1'b0, 32'h0, 32'h0, 4'h0, 2'd0, 1'b1, 1'b0};
        tbl[5]  = '{OP_SH,  32'h0000_3001, 32'h1111_2222, 0, 1'b0, 32'h0, 32'h0, 4'h0, 2'd0, 1'b0, 1'b1};
        tbl[6]  = '{OP_SH,  32'h0000_3002, 32'h1234_ABCD, 1, 1'b1, 32'h0000_3002, 32'hABCD_ABCD, 4'b1100, 2'd1, 1'b0, 1'b0};
        tbl[7]  = '{OP_SW,  32'h0000_4000, 32'hCAFE_F00D, 0, 1'b1, 32'h0000_4000, 32'hCAFE_F00D, 4'b1111, 2'd2, 1'b0, 1'b0};
        tbl[8]  = '{OP_LHU, 32'h0000_5002, 32'h5555_5555, 0, 1'b1, 32'h0000_5002, 32'h0, 4'b0000, 2'd1, 1'b0, 1'b0};
        tbl[9]  = '{OP_LWR, 32'h0000_6003, 32'h6666_6666, 1, 1'b1, 32'h0000_6000, 32'h0, 4'b0000, 2'd2, 1'b0, 1'b0};
        tbl[10] = '{OP_LB,  32'h0000_7001, 32'h0000_0000, 0, 1'b1, 32'h0000_7001, 32'h0, 4'b0000, 2'd0, 1'b0, 1'b0};
        tbl[11] = '{OP_SWL, 32'h0000_2003, 32'h1122_3344, 0, 1'b1, 32'h0000_2000, 32'h1122_3344, 4'b1111, 2'd2, 1'b0, 1'b0};
        tbl[12] = '{OP_SWR, 32'h0000_2003, 32'h1122_3344, 0, 1'b1, 32'h0000_2000, 32'h4400_0000, 4'b1000, 2'd2, 1'b0, 1'b0};
        tbl[13] = '{OP_SB,  32'h0000_1000, 32'h0000_00A5, 0, 1'b1, 32'h0000_1000, 32'hA5A5_A5A5, 4'b0001, 2'd0, 1'b0, 1'b0};

        resetn = 1'b0; valid_i = 1'b0; ready_i = 1'b0;
        pc_i = '0; inst_i = '0; ctrl_i = '0; result_i = '0; rdata2_i = '0; waddr_i = '0;
        data_addr_ok = 1'b0; data_data_ok = 1'b0;
        #3;
        chk("rst_ready", ready_o, 1);
        chk("rst_valid", valid_o, 0);
        chk("rst_req", data_req, 0);
        chk("rst_adel", adel_o, 0);
        chk("rst_ades", ades_o, 0);
        chk("rst_addr", data_addr, 0);
        chk("rst_wdata", data_wdata, 0);
        chk("rst_wstrb", data_wstrb, 0);
        chk("rst_size", data_size, 0);
        chk("rst_wr", data_wr, 0);
        chk("rst_result", result_o, 0);
        tick;
        resetn = 1'b1;

        for (int i = 0; i < 14; i++) run_vec(tbl[i], 32'hBFC0_0000 + 32'(i * 4));

        // Back-to-back loads: second request only in the first data_ok cycle
        tick;
        drive_instr(OP_LW, 32'h0000_4000, 32'h0, 32'h0000_0100);
        ready_i = 1'b0; data_addr_ok = 1'b0; data_data_ok = 1'b0;
        tick;
        valid_i = 1'b0; data_addr_ok = 1'b1;
        #2;
        chk("b2b_req1", data_req, 1);
        chk("b2b_addr1", data_addr, 32'h0000_4000);
        tick;
        data_addr_ok = 1'b0; ready_i = 1'b1;
        drive_instr(OP_LW, 32'h0000_4104, 32'h0, 32'h0000_0104);
        #2;
        chk("b2b_valid1", valid_o, 1);
        chk("b2b_result1", result_o, 32'h0000_4000);
        chk("b2b_ready", ready_o, 1);
        chk("b2b_idle_req", data_req, 0);
        tick;
        valid_i = 1'b0; ready_i = 1'b0; data_addr_ok = 1'b1;
        #2;
        chk("b2b_blocked", data_req, 0);
        chk("b2b_novalid", valid_o, 0);
        tick;
        data_data_ok = 1'b1; data_addr_ok = 1'b1;
        #2;
        chk("b2b_req2", data_req, 1);
        chk("b2b_addr2", data_addr, 32'h0000_4104);
        tick;
        data_addr_ok = 1'b0; data_data_ok = 1'b1; ready_i = 1'b1;
        #2;
        chk("b2b_valid2", valid_o, 1);
        chk("b2b_result2", result_o, 32'h0000_4104);
        chk("b2b_noreq2", data_req, 0);
        tick;
        data_data_ok = 1'b0; ready_i = 1'b0;
        #2;
        chk("b2b_done", valid_o, 0);
        chk("b2b_done_ready", ready_o, 1);

        // Asynchronous reset while a store request is pending
        tick;
        drive_instr(OP_SW, 32'h0000_8000, 32'h1357_9BDF, 32'h0000_0200);
        tick;
        valid_i = 1'b0;
        #2;
        chk("arst_req_before", data_req, 1);
        #1;
        resetn = 1'b0;
        #1;
        chk("arst_req", data_req, 0);
        chk("arst_valid", valid_o, 0);
        chk("arst_ready", ready_o, 1);
        chk("arst_wstrb", data_wstrb, 0);
        tick;
        tick;
        resetn = 1'b1;
        #2;
        chk("arst_post_ready", ready_o, 1);
        chk("arst_post_req", data_req, 0);
        run_vec(tbl[0], 32'h0000_0300);

        // Randomized traffic against the transaction-level model
        have = 1'b0; cur_mem = 1'b0; cur_done = 1'b0;
        outst = 0; ok_cd = -1;
        cur_op = OP_ADD; cur_a = '0; cur_rt = '0; cur_pc = '0;
        ce = model(OP_ADD, 32'h0, 32'h0);
        for (int cyc = 0; cyc < 1500; cyc++) begin
            tick;
            dok = (ok_cd == 0);
            data_data_ok = dok;
            data_addr_ok = ($urandom_range(0, 1) == 1);
            ready_i = ($urandom_range(0, 2) != 0);
            n_op = op_e'($urandom_range(0, 12));
            n_a = $urandom;
            if ($urandom_range(0, 1) == 1) n_a[1:0] = 2'b00;
            n_rt = $urandom;
            n_pc = $urandom;
            drive_instr(n_op, n_a, n_rt, n_pc);
            valid_i = ($urandom_range(0, 3) != 0);
            #2;
            exp_req   = have && cur_mem && !cur_done && ((outst == 0) || dok);
            exp_valid = have && (!cur_mem || cur_done);
            exp_rdy   = !have || (exp_valid && ready_i);
            chk("rnd_req", data_req, exp_req);
            chk("rnd_valid", valid_o, exp_valid);
            chk("rnd_ready", ready_o, exp_rdy);
            if (exp_req) begin
                chk("rnd_addr", data_addr, ce.addr);
                chk("rnd_size", data_size, ce.size);
                chk("rnd_wstrb", data_wstrb, ce.wstrb);
                chk("rnd_wr", data_wr, is_store(cur_op));
                if (is_store(cur_op)) chk("rnd_wdata", data_wdata, ce.wdata);
            end
            if (exp_valid) begin
                chk("rnd_pc", pc_o, cur_pc);
                chk("rnd_result", result_o, cur_a);
                chk("rnd_rdata2", rdata2_o, cur_rt);
                chk("rnd_ctrl", ctrl_o, op_ctrl(cur_op));
                chk("rnd_adel", adel_o, ce.adel);
                chk("rnd_ades", ades_o, ce.ades);
            end
            if (dok) begin
                outst = outst - 1;
                ok_cd = -1;
            end else if (ok_cd > 0) begin
                ok_cd = ok_cd - 1;
            end
            if (exp_req && data_addr_ok) begin
                outst = outst + 1;
                cur_done = 1'b1;
                ok_cd = int'($urandom_range(0, 3));
            end
            if (valid_i && exp_rdy) begin
                have = 1'b1;
                cur_op = n_op; cur_a = n_a; cur_rt = n_rt; cur_pc = n_pc;
                ce = model(n_op, n_a, n_rt);
                cur_mem = (is_load(n_op) || is_store(n_op)) && !ce.adel && !ce.ades;
                cur_done = 1'b0;
            end else if (exp_valid && ready_i) begin
                have = 1'b0;
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
